booth_mul32: RTL
================

// Module: booth_mul32
// PURPOSE
//   Multi-cycle signed 32x32 -> 64-bit multiplier (radix-2 Booth) for the ALU MUL path.
//   Sits directly upstream and downstream of adder32: it drives adder32 RA/RB/c_in each
//   cycle and consumes sum/c_out. The 64-bit product is written to the HI/LO pair.
//   Start/busy/done handshake toward the ALU control unit.
// PARAMETERS
//   WIDTH    32  operand width; must equal adder32 width, and 32 is the only legal value
//   CNT_W    5   iteration counter width, = log2(WIDTH)
// PORTS
//   clk           in   1   rising-edge clock
//   rst_n         in   1   asynchronous reset, active-low
//   start         in   1   request; sampled only in IDLE
//   multiplicand  in   32  signed M; sampled with start
//   multiplier    in   32  signed Q; sampled with start
//   busy          out  1   1 in RUN and DONE
//   done          out  1   1-cycle pulse; hi/lo valid from this cycle
//   hi            out  32  product[63:32]; held until the next completion
//   lo            out  32  product[31:0];  held until the next completion
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, A=0, Q=0, M=0, q_1=0, count=0, hi=0, lo=0,
//     busy=0, done=0. Asserting reset mid-run aborts the run with no result and no done.
//   States: IDLE, RUN, DONE. busy = (state != IDLE); done = (state == DONE).
//   IDLE: on start=1 at edge E0, load M<=multiplicand, Q<=multiplier, A<=0, q_1<=0,
//     count<=0, then go to RUN. With start=0, stay in IDLE.
//   RUN: one Booth step per edge (edges E1..E32):
//     {Q[0],q_1}=01: RA=A, RB=M,  c_in=0 (A+M)
//     {Q[0],q_1}=10: RA=A, RB=~M, c_in=1 (A-M)
//     00 or 11:      RA=A, RB=0,  c_in=0 (pass)
//     ext = RA[31]^RB[31]^c_out (true 33rd bit of the sum; avoids overflow when M=-2^31)
//     {A,Q,q_1} <= {ext, sum, Q} >> 1 (keep the low 65 bits, i.e. an arithmetic shift right)
//     count <= count+1. On the step with count==31 (edge E32), go to DONE.
//     On the same edge, load hi<=next A and lo<=next Q.
//   DONE: present for exactly 1 cycle (between E32 and E33), then go to IDLE at E33.
//   Latency: done=1 in the 32nd cycle after the start-sampling edge E0.
//     Throughput: a new start is accepted no earlier than the IDLE cycle following E33.
//   start while busy (RUN or DONE) is ignored: not queued, operands not resampled.
//   Operand inputs may change freely after E0; only the latched M and Q are used.
//   hi/lo change only at the completion edge and hold otherwise, including during
//     the next run.
//   Arithmetic is two's complement mod 2^64. All 2^64 signed operand pairs are exact,
//     including (-2^31)*(-2^31) = +2^62.
//   The adder is purely combinational. The critical path is one adder32 plus the
//     RB mux; there are no multicycle paths.
// STRUCTURE
//   Shared include cpu_defs.vh holds: WORD_W=32, MUL_CNT_W=5, and state encodings
//     ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2. Other multi-cycle units (a divider)
//     reuse these.
//   Exactly one sub-module: the existing adder32, instantiated once (u_add). The
//     RB/c_in mux, state register, counter and A/Q/q_1 shift register are local logic.
//     Do not build a second adder.
// TESTING
//   1. 3 * 5: start at E0 -> busy=1 from E0, done=1 exactly 32 cycles later,
//      hi=32'h0000_0000, lo=32'h0000_000F.
//   2. -7 * 6 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFD6.
//      0 * 32'hDEAD_BEEF -> hi=0, lo=0.
//   3. 32'h8000_0000 * 32'h8000_0000 -> hi=32'h4000_0000, lo=0.
//      32'h7FFF_FFFF * 32'h7FFF_FFFF -> hi=32'h3FFF_FFFF, lo=32'h0000_0001.
//      32'h8000_0000 * 32'h7FFF_FFFF -> hi=32'hC000_0000, lo=32'h8000_0000.
//   4. Pulse start with 2*2 at cycle 10 of a 9*9 run -> result is 81 (lo=32'h51).
//      One done pulse only; the second start is dropped. The next start is accepted
//      in IDLE.
//   5. rst_n=0 at cycle 15 of a run -> busy=0 and hi=lo=0 immediately (async), no done.
//      After release, 4*4 completes normally with lo=32'h10.
//   6. Random signed pairs (>=10k) checked against the $signed 64-bit product.
//      Also check that hi/lo stay constant between done pulses.

Source files
------------

// File: rtl/booth_mul32_pkg.sv
`default_nettype none
// ============================================================================
// Module  : booth_mul32_pkg
// Brief   : Shared widths and state encodings for multi-cycle ALU units
//           (Booth multiplier, divider).
// Contents: WORD_W    - datapath word width
//           MUL_CNT_W - multiplier iteration counter width, log2(WORD_W)
//           ST_*      - 2-bit state encodings shared by multi-cycle units
// Revision: 1.0 - initial release
// ============================================================================
package booth_mul32_pkg;

    localparam int WORD_W    = 32;
    localparam int MUL_CNT_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : booth_mul32_pkg
`default_nettype wire

// File: rtl/adder32.sv
`default_nettype none
// ============================================================================
// Module  : adder32
// Brief   : Purely combinational ripple/inferred adder with carry in/out.
// Ports   : ra    in  WIDTH  operand A
//           rb    in  WIDTH  operand B
//           c_in  in  1      carry in
//           sum   out WIDTH  ra + rb + c_in (low WIDTH bits)
//           c_out out 1      carry out of the top bit
// Revision: 1.0 - initial release
// ============================================================================
module adder32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    assign {c_out, sum} = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, c_in};

endmodule : adder32
`default_nettype wire

// File: rtl/booth_mul32.sv
`default_nettype none
// ============================================================================
// Module  : booth_mul32
// Brief   : Multi-cycle signed 32x32 -> 64-bit radix-2 Booth multiplier.
//           One Booth step per clock through a single shared adder32.
// Ports   : clk          in  1   rising-edge clock
//           rst_n        in  1   asynchronous reset, active-low
//           start        in  1   request, sampled only in IDLE
//           multiplicand in  32  signed M, sampled with start
//           multiplier   in  32  signed Q, sampled with start
//           busy         out 1   high in RUN and DONE
//           done         out 1   one-cycle pulse, hi/lo valid from this cycle
//           hi           out 32  product[63:32], held until next completion
//           lo           out 32  product[31:0],  held until next completion
// Revision: 1.0 - initial release
// ============================================================================
module booth_mul32
    import booth_mul32_pkg::*;
#(
    parameter int WIDTH = WORD_W,     // only 32 is supported
    parameter int CNT_W = MUL_CNT_W   // log2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_q_1;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_ra;
    logic [WIDTH-1:0] w_rb;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ext;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_q_next;

    // Booth recoding of {Q[0], q_1}: add M, subtract M (as ~M + 1), or pass A.
    always_comb begin
        w_rb  = '0;
        w_cin = 1'b0;
        case ({r_q[0], r_q_1})
            2'b01: begin
                w_rb  = r_m;
            end
            2'b10: begin
                w_rb  = ~r_m;
                w_cin = 1'b1;
            end
            default: begin
                w_rb  = '0;
                w_cin = 1'b0;
            end
        endcase
    end

    assign w_ra = r_a;

    adder32 #(
        .WIDTH (WIDTH)
    ) u_add (
        .ra    (w_ra),
        .rb    (w_rb),
        .c_in  (w_cin),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    // Sign of the true 33-bit sum. Using this instead of sum[31] keeps the
    // arithmetic shift correct when A +/- M overflows 32 bits (M = -2^31).
    assign w_ext = w_ra[WIDTH-1] ^ w_rb[WIDTH-1] ^ w_cout;

    // {A, Q, q_1} <= {ext, sum, Q} >> 1
    assign w_a_next = {w_ext, w_sum[WIDTH-1:1]};
    assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_q_1   <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_a     <= '0;
                        r_q_1   <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= w_a_next;
                    r_q     <= w_q_next;
                    r_q_1   <= r_q[0];
                    r_count <= r_count + 1'b1;
                    // Last step: publish the product directly from the
                    // next-state values so hi/lo are valid with done.
                    if (r_count == '1) begin
                        r_hi    <= w_a_next;
                        r_lo    <= w_q_next;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : booth_mul32
`default_nettype wire
